// File: rtl/rts_sig_checker_if.sv
// rtl/rts_sig_checker_if.sv - signature checker bus; learn port present only with RTS_LEARN_EN
interface rts_sig_checker_if #(
    parameter int MISR_Size = 10,
    parameter int SISA_Size = 16,
    parameter int CNT_W     = 16
);
    logic                 start;
    logic                 done;
    logic [MISR_Size-1:0] MISR_Out;
    logic [SISA_Size-1:0] SISA_Out;
    logic                 golden_we;
    logic [MISR_Size-1:0] golden_misr;
    logic [SISA_Size-1:0] golden_sisa;
    logic                 clear;
`ifdef RTS_LEARN_EN
    logic                 learn;
`endif
    logic                 busy;
    logic                 sig_valid;
    logic                 pass;
    logic                 fail;
    logic [1:0]           mismatch;
    logic [CNT_W-1:0]     session_cnt;
    logic [CNT_W-1:0]     fail_cnt;
    logic                 wr_err;

    modport master (
        output start, done, MISR_Out, SISA_Out, golden_we, golden_misr, golden_sisa, clear,
`ifdef RTS_LEARN_EN
        output learn,
`endif
        input  busy, sig_valid, pass, fail, mismatch, session_cnt, fail_cnt, wr_err
    );

    modport slave (
        input  start, done, MISR_Out, SISA_Out, golden_we, golden_misr, golden_sisa, clear,
`ifdef RTS_LEARN_EN
        input  learn,
`endif
        output busy, sig_valid, pass, fail, mismatch, session_cnt, fail_cnt, wr_err
    );
endinterface

// File: rtl/rts_sig_checker.sv
// rtl/rts_sig_checker.sv - compares RTS MISR/SISA signatures against golden values; RTS_LEARN_EN adds learning sessions
module rts_sig_checker #(
    parameter int MISR_Size = 10,
    parameter int SISA_Size = 16,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               masterRstN,
    rts_sig_checker_if.slave   bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ARMED  = 2'd1;
    localparam logic [1:0] CHECK  = 2'd2;
    localparam logic [1:0] REPORT = 2'd3;

    logic [1:0]           state;
    logic                 done_q;
    logic [MISR_Size-1:0] gold_misr;
    logic [SISA_Size-1:0] gold_sisa;
    logic [MISR_Size-1:0] cap_misr;
    logic [SISA_Size-1:0] cap_sisa;
    logic                 pass_r;
    logic                 fail_r;
    logic [1:0]           mismatch_r;
    logic [CNT_W-1:0]     session_cnt_r;
    logic [CNT_W-1:0]     fail_cnt_r;
    logic                 wr_err_r;
    logic                 done_rise;
    logic [1:0]           cmp;
    logic                 learning;

    // done_q follows done in every state, so a level already high when armed never looks like an edge
    assign done_rise = bus.done & ~done_q;
    assign cmp       = {(cap_misr != gold_misr), (cap_sisa != gold_sisa)};

`ifdef RTS_LEARN_EN
    logic learn_q;
    assign learning = learn_q;
`else
    assign learning = 1'b0;
`endif

    always_ff @(posedge clk or negedge masterRstN) begin
        if (!masterRstN) begin
            state         <= IDLE;
            done_q        <= 1'b0;
            gold_misr     <= '0;
            gold_sisa     <= '0;
            cap_misr      <= '0;
            cap_sisa      <= '0;
            pass_r        <= 1'b0;
            fail_r        <= 1'b0;
            mismatch_r    <= 2'b00;
            session_cnt_r <= '0;
            fail_cnt_r    <= '0;
            wr_err_r      <= 1'b0;
`ifdef RTS_LEARN_EN
            learn_q       <= 1'b0;
`endif
        end else begin
            done_q <= bus.done;
            case (state)
                IDLE: begin
                    if (bus.golden_we) begin
                        gold_misr <= bus.golden_misr;
                        gold_sisa <= bus.golden_sisa;
                    end
                    if (bus.start) begin
                        state <= ARMED;
`ifdef RTS_LEARN_EN
                        learn_q <= bus.learn;
`endif
                    end
                end
                ARMED: begin
                    if (done_rise) begin
                        cap_misr <= bus.MISR_Out;
                        cap_sisa <= bus.SISA_Out;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    state <= REPORT;
                    if (learning) begin
                        gold_misr  <= cap_misr;
                        gold_sisa  <= cap_sisa;
                        mismatch_r <= 2'b00;
                        fail_r     <= 1'b0;
                        pass_r     <= 1'b1;
                    end else begin
                        mismatch_r <= cmp;
                        fail_r     <= |cmp;
                        pass_r     <= ~|cmp;
                        if (~&session_cnt_r)
                            session_cnt_r <= session_cnt_r + 1'b1;
                        if ((|cmp) && (~&fail_cnt_r))
                            fail_cnt_r <= fail_cnt_r + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (bus.golden_we && (state != IDLE))
                wr_err_r <= 1'b1;

            // clear is last so it overrides any increment landing in the same cycle
            if (bus.clear) begin
                session_cnt_r <= '0;
                fail_cnt_r    <= '0;
                wr_err_r      <= 1'b0;
            end
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.sig_valid   = (state == REPORT);
    assign bus.pass        = pass_r;
    assign bus.fail        = fail_r;
    assign bus.mismatch    = mismatch_r;
    assign bus.session_cnt = session_cnt_r;
    assign bus.fail_cnt    = fail_cnt_r;
    assign bus.wr_err      = wr_err_r;
endmodule

// File: tb/tb_rts_sig_checker.sv
// tb/tb_rts_sig_checker.sv - self-checking bench for rts_sig_checker (CNT_W=4); learning checks need RTS_LEARN_EN
module tb_rts_sig_checker;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    logic [9:0]  m_gm;
    logic [15:0] m_gs;
    int          m_sess;
    int          m_fail;
    logic [1:0]  e_mm;

    typedef struct {
        logic [9:0]  misr;
        logic [15:0] sisa;
        logic        exp_pass;
        logic [1:0]  exp_mm;
    } vec_t;
    vec_t vecs[5];

    rts_sig_checker_if #(.MISR_Size(10), .SISA_Size(16), .CNT_W(4)) bus ();

    rts_sig_checker #(.MISR_Size(10), .SISA_Size(16), .CNT_W(4)) dut (
        .clk        (clk),
        .masterRstN (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_valid"}, 32'(bus.sig_valid), 0);
        chk({tag, "_pass"}, 32'(bus.pass), 0);
        chk({tag, "_fail"}, 32'(bus.fail), 0);
        chk({tag, "_mm"}, 32'(bus.mismatch), 0);
        chk({tag, "_sess"}, 32'(bus.session_cnt), 0);
        chk({tag, "_fcnt"}, 32'(bus.fail_cnt), 0);
        chk({tag, "_wrerr"}, 32'(bus.wr_err), 0);
    endtask

    task automatic expect_result(input logic [9:0] misr, input logic [15:0] sisa, input bit learn_s);
        if (learn_s) begin
            m_gm = misr;
            m_gs = sisa;
            e_mm = 2'b00;
        end else begin
            e_mm = {misr != m_gm, sisa != m_gs};
            if (m_sess < 15) m_sess++;
            if (e_mm != 2'b00 && m_fail < 15) m_fail++;
        end
        chk("valid", 32'(bus.sig_valid), 1);
        chk("mismatch", 32'(bus.mismatch), 32'(e_mm));
        chk("fail", 32'(bus.fail), 32'(e_mm != 2'b00));
        chk("pass", 32'(bus.pass), 32'(e_mm == 2'b00));
        chk("session_cnt", 32'(bus.session_cnt), 32'(m_sess));
        chk("fail_cnt", 32'(bus.fail_cnt), 32'(m_fail));
    endtask

    task automatic session(input logic [9:0] misr, input logic [15:0] sisa, input bit learn_s,
                           input bit we, input logic [9:0] gm, input logic [15:0] gs);
        bus.done  = 1'b0;
        bus.start = 1'b1;
`ifdef RTS_LEARN_EN
        bus.learn = learn_s;
`endif
        bus.golden_we   = we;
        bus.golden_misr = gm;
        bus.golden_sisa = gs;
        if (we) begin
            m_gm = gm;
            m_gs = gs;
        end
        tick();
        bus.start     = 1'b0;
        bus.golden_we = 1'b0;
        chk("busy_armed", 32'(bus.busy), 1);
        bus.MISR_Out = misr;
        bus.SISA_Out = sisa;
        bus.done     = 1'b1;
        tick();
        bus.done     = 1'b0;
        bus.MISR_Out = ~misr;
        bus.SISA_Out = ~sisa;
        chk("no_valid_in_check", 32'(bus.sig_valid), 0);
        tick();
        expect_result(misr, sisa, learn_s);
        tick();
        chk("valid_one_cycle", 32'(bus.sig_valid), 0);
        chk("idle_after", 32'(bus.busy), 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_gm = '0; m_gs = '0; m_sess = 0; m_fail = 0; e_mm = '0;
        rst_n = 1'b0;
        bus.start = 0; bus.done = 0; bus.MISR_Out = '0; bus.SISA_Out = '0;
        bus.golden_we = 0; bus.golden_misr = '0; bus.golden_sisa = '0; bus.clear = 0;
`ifdef RTS_LEARN_EN
        bus.learn = 0;
`endif
        vecs[0] = '{10'h2A5, 16'h1234, 1'b1, 2'b00};
        vecs[1] = '{10'h2A5, 16'h1235, 1'b0, 2'b01};
        vecs[2] = '{10'h2A4, 16'h1234, 1'b0, 2'b10};
        vecs[3] = '{10'h000, 16'h0000, 1'b0, 2'b11};
        vecs[4] = '{10'h2A5, 16'h1234, 1'b1, 2'b00};

        #12;
        chk_zero("reset");
        #2 rst_n = 1'b1;
        tick();

        // golden load together with start uses the new golden value
        session(10'h2A5, 16'h1234, 1'b0, 1'b1, 10'h2A5, 16'h1234);
        chk("first_pass", 32'(bus.pass), 1);
        chk("first_sess", 32'(bus.session_cnt), 1);

        for (int i = 0; i < 5; i++) begin
            session(vecs[i].misr, vecs[i].sisa, 1'b0, 1'b0, 10'h0, 16'h0);
            chk($sformatf("vec%0d_pass", i), 32'(bus.pass), 32'(vecs[i].exp_pass));
            chk($sformatf("vec%0d_mm", i), 32'(bus.mismatch), 32'(vecs[i].exp_mm));
        end

        // done already high when armed must not count
        bus.done = 1'b1;
        tick();
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("held_done_no_valid", 32'(bus.sig_valid), 0);
            chk("held_done_busy", 32'(bus.busy), 1);
            tick();
        end
        bus.done = 1'b0;
        bus.MISR_Out = m_gm;
        bus.SISA_Out = m_gs;
        tick();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        tick();
        expect_result(m_gm, m_gs, 1'b0);
        tick();

        // golden write while armed is dropped and flagged
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.golden_we = 1'b1;
        bus.golden_misr = 10'h3FF;
        bus.golden_sisa = 16'hFFFF;
        tick();
        bus.golden_we = 1'b0;
        chk("wr_err_set", 32'(bus.wr_err), 1);
        bus.MISR_Out = m_gm;
        bus.SISA_Out = m_gs;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        tick();
        expect_result(m_gm, m_gs, 1'b0);
        chk("golden_kept", 32'(bus.pass), 1);
        tick();
        chk("wr_err_sticky", 32'(bus.wr_err), 1);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        m_sess = 0; m_fail = 0;
        chk("clear_wr_err", 32'(bus.wr_err), 0);
        chk("clear_sess", 32'(bus.session_cnt), 0);
        chk("clear_fcnt", 32'(bus.fail_cnt), 0);

        // clear beats the increment in the same cycle
        session(10'h2A5, 16'h1234, 1'b0, 1'b0, 10'h0, 16'h0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.MISR_Out = m_gm;
        bus.SISA_Out = ~m_gs;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        chk("clrpri_valid", 32'(bus.sig_valid), 1);
        chk("clrpri_sess", 32'(bus.session_cnt), 0);
        chk("clrpri_fcnt", 32'(bus.fail_cnt), 0);
        chk("clrpri_fail", 32'(bus.fail), 1);
        m_sess = 0; m_fail = 0;
        tick();

        // clear together with start in IDLE
        session(10'h2A5, 16'h0, 1'b0, 1'b0, 10'h0, 16'h0);
        bus.clear = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.start = 1'b0;
        m_sess = 0; m_fail = 0;
        chk("clrstart_busy", 32'(bus.busy), 1);
        chk("clrstart_sess", 32'(bus.session_cnt), 0);
        bus.MISR_Out = m_gm;
        bus.SISA_Out = m_gs;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        tick();
        expect_result(m_gm, m_gs, 1'b0);
        tick();

        // fail_cnt saturation
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        m_sess = 0; m_fail = 0;
        for (int i = 0; i < 16; i++)
            session(~m_gm, m_gs, 1'b0, 1'b0, 10'h0, 16'h0);
        chk("fail_cnt_sat", 32'(bus.fail_cnt), 32'hF);
        chk("sess_cnt_sat", 32'(bus.session_cnt), 32'hF);

        // randomized sessions against the model
        for (int i = 0; i < 40; i++) begin
            logic [9:0]  rm;
            logic [15:0] rs;
            logic [9:0]  ngm;
            logic [15:0] ngs;
            bit          we;
            we  = ($urandom_range(0, 5) == 0);
            ngm = 10'($urandom);
            ngs = 16'($urandom);
            if (i % 10 == 0) begin
                bus.clear = 1'b1;
                tick();
                bus.clear = 1'b0;
                m_sess = 0; m_fail = 0;
            end
            rm = $urandom_range(0, 1) ? (we ? ngm : m_gm) : 10'($urandom);
            rs = $urandom_range(0, 1) ? (we ? ngs : m_gs) : 16'($urandom);
            session(rm, rs, 1'b0, we, ngm, ngs);
        end

        // asynchronous reset in CHECK abandons the session
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.MISR_Out = m_gm;
        bus.SISA_Out = m_gs;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        tick();
        #3 rst_n = 1'b1;
        m_gm = '0; m_gs = '0; m_sess = 0; m_fail = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_no_valid", 32'(bus.sig_valid), 0);
            chk("post_rst_idle", 32'(bus.busy), 0);
        end
        session(10'h000, 16'h0000, 1'b0, 1'b0, 10'h0, 16'h0);
        chk("golden_zeroed", 32'(bus.pass), 1);

`ifdef RTS_LEARN_EN
        session(10'h155, 16'h1234, 1'b1, 1'b0, 10'h0, 16'h0);
        chk("learn_sess_cnt", 32'(bus.session_cnt), 1);
        session(10'h155, 16'h1234, 1'b0, 1'b0, 10'h0, 16'h0);
        chk("learned_pass", 32'(bus.pass), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rts_sig_checker.md
RTS_SIG_CHECKER -- requirements
Module: rts_sig_checker

Interface
REQ-001 SHALL have parameter MISR_Size, default 10, MISR signature width.
REQ-002 SHALL have parameter SISA_Size, default 16, SISA signature width.
REQ-003 SHALL have parameter CNT_W, default 16, session and fail counter width.
REQ-004 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port masterRstN  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that arms a session; issued with the controller's masterRst pulse.
REQ-007 SHALL have port done  input  1  end-of-session flag from the RTS controller; level input, rising edge significant.
REQ-008 SHALL have port MISR_Out  input  MISR_Size  MISR signature.
REQ-009 SHALL have port SISA_Out  input  SISA_Size  SISA signature.
REQ-010 SHALL have port golden_we  input  1  golden signature write strobe.
REQ-011 SHALL have ports golden_misr and golden_sisa  input  MISR_Size and SISA_Size  golden signature data.
REQ-012 SHALL have port clear  input  1  synchronous clear of counters and error flag.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port sig_valid  output  1  one-cycle pulse; result outputs valid.
REQ-015 SHALL have ports pass and fail  output  1 each  result of the last session; held until the next sig_valid.
REQ-016 SHALL have port mismatch  output  2  {MISR mismatch, SISA mismatch} of the last session.
REQ-017 SHALL have ports session_cnt and fail_cnt  output  CNT_W each  sessions completed and sessions failed.
REQ-018 SHALL have port wr_err  output  1  sticky; set when golden_we arrives outside IDLE.

Function
REQ-019 SHALL implement FSM IDLE -> ARMED (start) -> CHECK (done rising edge) -> REPORT -> IDLE.
REQ-020 SHALL detect the rising edge of done as done=1 with the registered previous done=0; a done already high at start SHALL NOT count, so a fresh edge is required.
REQ-021 SHALL capture MISR_Out and SISA_Out in the cycle the edge is detected (edge cycle N).
REQ-022 SHALL compare captured values against the golden registers in CHECK (cycle N+1).
REQ-023 SHALL, in REPORT (cycle N+2), pulse sig_valid, update pass, fail and mismatch, and increment session_cnt, and increment fail_cnt on fail.
REQ-024 SHALL drive fail = |mismatch and pass = ~fail.
REQ-025 SHALL saturate both counters at all-ones with no wrap-around.
REQ-026 SHALL ignore start outside IDLE.
REQ-027 SHALL load golden registers on golden_we only in IDLE; outside IDLE it SHALL drop the write and set wr_err.
REQ-028 SHALL, on clear, zero session_cnt, fail_cnt and wr_err in any state without affecting the FSM.
REQ-029 SHALL give clear priority over a REPORT increment in the same cycle (counters read 0 afterwards).
REQ-030 SHALL honour clear and start together in IDLE by clearing and arming.
REQ-031 SHALL accept golden_we and start together in IDLE: load the golden value and arm, using the new golden value for the session.

Reset
REQ-032 SHALL, on masterRstN=0 and immediately without waiting for a clock edge, enter IDLE and zero busy, sig_valid, pass, fail, mismatch, session_cnt, fail_cnt, wr_err, the golden registers, the capture registers and the done history.
REQ-033 SHALL abandon a session on reset mid-session with no result and no counter change; operation resumes on the first clk edge after masterRstN returns to 1.

Configuration
REQ-034 SHALL, with RTS_LEARN_EN defined, add input learn (1 bit) sampled with start; for a learning session it SHALL write the captured signature into the golden registers at REPORT, pulse sig_valid with pass=1 and mismatch=0, and leave both counters unchanged.
REQ-035 SHALL, with RTS_LEARN_EN undefined, omit the learn port and compare every session.

Verification
REQ-036 SHALL cover: golden 10'h2A5/16'h1234; start; done rises with MISR=10'h2A5, SISA=16'h1234 -> sig_valid two cycles after the edge, pass=1, mismatch=00, session_cnt=1, fail_cnt=0.
REQ-037 SHALL cover: same golden; done rises with SISA=16'h1235 -> fail=1, mismatch=01, fail_cnt=1.
REQ-038 SHALL cover: done held high at start -> no sig_valid until done drops and rises again.
REQ-039 SHALL cover: fail_cnt preset to all-ones by 2^CNT_W-1 failing sessions (CNT_W=4 bench) and one more fail -> fail_cnt stays 4'hF.
REQ-040 SHALL cover: golden_we in ARMED -> golden registers unchanged and wr_err=1; then clear -> wr_err=0 and counters 0.
REQ-041 SHALL cover: masterRstN low in CHECK -> all outputs 0 asynchronously and no sig_valid after release; with RTS_LEARN_EN, learn=1 with MISR=10'h155 -> golden_misr register becomes 10'h155 and the next matching session passes.
